hazard_forward_unit: RTL and testbench

//  Parametrised hazard/forwarding unit for the in-order RISC-V pipeline.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_src_match.sv | 59 +++++
 rtl/hazard_forward_unit.sv | 139 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit.
// Holds:
//   - the tracked-entry field widths;
//   - the regfile forward-select code;
//   - the select-width function;
//   - the parameter-legality check used by the top level.
package hazard_pkg;

    // Width of each tracked-entry control flag (valid, we, is_load).
    localparam int ENTRY_FLAG_W = 1;
    // Number of control flags per tracked entry.
    localparam int ENTRY_CTRL_W = 3 * ENTRY_FLAG_W;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Width of a forward select able to encode 0 (regfile) and stages 1..depth.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal configurations:
    //   - depth is in 2..7;
    //   - the load becomes forwardable from a stage that is actually tracked.
    function automatic bit fwd_params_legal(input int depth, input int load_lat);
        return (depth >= 2) && (depth <= 7) && (load_lat >= 1) && (load_lat < depth);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source match and priority encoder.
// Compares one ID source register against every tracked stage and returns the
// youngest matching stage number plus whether that producer is a load.
// Ports:
//   rs          in  source register index
//   rs_used     in  the operand is actually read
//   id_valid    in  ID holds a real instruction
//   stage_valid in  per-stage valid, bit 0 = stage 1
//   stage_we    in  per-stage write enable
//   stage_load  in  per-stage is_load
//   stage_rd    in  per-stage destination, stage 1 in LSBs
//   sel         out 0 = regfile, k = stage k
//   is_load_hit out the winning producer is a load
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int SEL_W     = 2
) (
    input  logic [REG_AW-1:0]           rs,
    input  logic                        rs_used,
    input  logic                        id_valid,
    input  logic [FWD_DEPTH-1:0]        stage_valid,
    input  logic [FWD_DEPTH-1:0]        stage_we,
    input  logic [FWD_DEPTH-1:0]        stage_load,
    input  logic [FWD_DEPTH*REG_AW-1:0] stage_rd,
    output logic [SEL_W-1:0]            sel,
    output logic                        is_load_hit
);

    logic [FWD_DEPTH-1:0] match_s;
    logic [SEL_W-1:0]     sel_s;
    logic                 load_hit_s;

    // Per-stage match; x0 is never a producer and unused operands never match.
    always_comb begin
        match_s = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            match_s[k] = stage_valid[k] & stage_we[k] &
                         (stage_rd[k*REG_AW +: REG_AW] == rs) &
                         (rs != {REG_AW{1'b0}}) & rs_used & id_valid;
        end
    end

    // Priority encode: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel_s      = SEL_W'(FWD_SEL_RF);
        load_hit_s = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            sel_s      = match_s[k-1] ? SEL_W'(k) : sel_s;
            load_hit_s = match_s[k-1] ? stage_load[k-1] : load_hit_s;
        end
    end

    assign sel         = sel_s;
    assign is_load_hit = load_hit_s;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard / forwarding unit for the in-order RISC-V pipeline.
// Tracks destinations of in-flight instructions over FWD_DEPTH post-ID stages
// (1=EX, 2=MEM, ...).
// It produces:
//   - a combinational forward select per ID source operand;
//   - an ID stall for load-use hazards.
// Optional feature macro: HAZARD_STALL_CNT_EN adds a saturating stall counter.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   id_valid      ID holds a real instruction
//   id_rs         source indices, src0 in LSBs
//   id_rs_used    per-source operand-used flags
//   id_rd, id_we  destination and write enable
//   id_is_load    instruction is a load
//   pipe_advance  1 = pipeline moves this cycle, 0 = global hold
//   flush         squash the ID instruction
//   fwd_sel       per-source select, 0 = regfile, k = stage k
//   stall_id      hold IF/ID and insert a bubble into EX
//   stall_cnt     (HAZARD_STALL_CNT_EN only) advancing stall cycles
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int REG_AW    = 5,
    parameter  int FWD_DEPTH = 3,
    parameter  int LOAD_LAT  = 1,
    localparam int SEL_W     = sel_w(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      pipe_advance,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall_id
`ifdef HAZARD_STALL_CNT_EN
   ,output logic [31:0]               stall_cnt
`endif
);

    generate
        if (!fwd_params_legal(FWD_DEPTH, LOAD_LAT)) begin : g_bad_params
            $error("hazard_forward_unit: need 2<=FWD_DEPTH<=7 and 1<=LOAD_LAT<FWD_DEPTH");
        end
    endgenerate

    // Tracked stages; bit/slice 0 is stage 1 (EX).
    logic [FWD_DEPTH-1:0]        stage_valid_r;
    logic [FWD_DEPTH-1:0]        stage_we_r;
    logic [FWD_DEPTH-1:0]        stage_load_r;
    logic [FWD_DEPTH*REG_AW-1:0] stage_rd_r;

    logic [NUM_SRC*SEL_W-1:0]    sel_all_s;
    logic [NUM_SRC-1:0]          load_hit_s;
    logic [NUM_SRC-1:0]          hazard_s;
    logic                        stall_s;
    logic                        issue_s;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            hazard_src_match #(
                .REG_AW    (REG_AW),
                .FWD_DEPTH (FWD_DEPTH),
                .SEL_W     (SEL_W)
            ) u_match (
                .rs          (id_rs[s*REG_AW +: REG_AW]),
                .rs_used     (id_rs_used[s]),
                .id_valid    (id_valid),
                .stage_valid (stage_valid_r),
                .stage_we    (stage_we_r),
                .stage_load  (stage_load_r),
                .stage_rd    (stage_rd_r),
                .sel         (sel_all_s[s*SEL_W +: SEL_W]),
                .is_load_hit (load_hit_s[s])
            );
        end
    endgenerate

    // A load hit is a hazard while the load sits before its forwardable stage.
    always_comb begin
        hazard_s = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            hazard_s[s] = load_hit_s[s] &
                          (sel_all_s[s*SEL_W +: SEL_W] < SEL_W'(LOAD_LAT + 1));
        end
    end

    // A flushed ID instruction is discarded anyway, so it never stalls.
    always_comb begin
        stall_s = (|hazard_s) & ~flush;
        issue_s = id_valid & ~stall_s & ~flush;
    end

    // Stage shift register; moves only on an advancing cycle, bubble on stall/flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid_r <= '0;
            stage_we_r    <= '0;
            stage_load_r  <= '0;
            stage_rd_r    <= '0;
        end else if (pipe_advance) begin
            stage_valid_r <= {stage_valid_r[FWD_DEPTH-2:0], issue_s};
            stage_we_r    <= {stage_we_r[FWD_DEPTH-2:0], id_we};
            stage_load_r  <= {stage_load_r[FWD_DEPTH-2:0], id_is_load};
            stage_rd_r    <= {stage_rd_r[(FWD_DEPTH-1)*REG_AW-1:0], id_rd};
        end else begin
            stage_valid_r <= stage_valid_r;
            stage_we_r    <= stage_we_r;
            stage_load_r  <= stage_load_r;
            stage_rd_r    <= stage_rd_r;
        end
    end

    assign fwd_sel  = sel_all_s;
    assign stall_id = stall_s;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stall cycles that actually inserted a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (stall_s && pipe_advance && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit.
// dut : default configuration (FWD_DEPTH=3, LOAD_LAT=1), table-driven.
// dut2: FWD_DEPTH=4, LOAD_LAT=2, shares the inputs and is used by the
//       two-bubble sequence.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        pipe_advance;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall_id;
    logic [5:0]  fwd_sel2;
    logic        stall_id2;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt2;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .pipe_advance(pipe_advance), .flush(flush),
        .fwd_sel(fwd_sel), .stall_id(stall_id)
`ifdef HAZARD_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    hazard_forward_unit #(.FWD_DEPTH(4), .LOAD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .pipe_advance(pipe_advance), .flush(flush),
        .fwd_sel(fwd_sel2), .stall_id(stall_id2)
`ifdef HAZARD_STALL_CNT_EN
       ,.stall_cnt(stall_cnt2)
`endif
    );

    typedef struct {
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       adv;
        logic       fl;
        logic       chk_sel;
        logic [1:0] e0;
        logic [1:0] e1;
        logic       est;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] used, input logic [4:0] rd, input logic we,
                                input logic ld, input logic adv, input logic fl,
                                input logic chk_sel, input logic [1:0] e0, input logic [1:0] e1,
                                input logic est);
        vec_t r;
        r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd; r.we = we;
        r.ld = ld; r.adv = adv; r.fl = fl; r.chk_sel = chk_sel;
        r.e0 = e0; r.e1 = e1; r.est = est;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic we,
                         input logic ld, input logic adv, input logic fl);
        id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
        id_we = we; id_is_load = ld; pipe_advance = adv; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Stage contents after each row noted as s1/s2/s3.
        tbl[0]  = mk(1, 5'd1,  5'd2,  2'b11, 5'd5,  1, 0, 1, 0, 1, 2'd0, 2'd0, 0); // s1=x5
        tbl[1]  = mk(1, 5'd5,  5'd0,  2'b11, 5'd6,  1, 0, 1, 0, 1, 2'd1, 2'd0, 0); // back-to-back
        tbl[2]  = mk(1, 5'd5,  5'd6,  2'b11, 5'd7,  1, 0, 1, 0, 1, 2'd2, 2'd1, 0); // s=x7,x6,x5
        tbl[3]  = mk(1, 5'd5,  5'd7,  2'b11, 5'd7,  1, 0, 1, 0, 1, 2'd3, 2'd1, 0); // s=x7,x7,x6
        tbl[4]  = mk(1, 5'd7,  5'd6,  2'b11, 5'd0,  1, 0, 1, 0, 1, 2'd1, 2'd3, 0); // youngest wins
        tbl[5]  = mk(1, 5'd0,  5'd7,  2'b11, 5'd8,  0, 0, 1, 0, 1, 2'd0, 2'd2, 0); // x0 in s1
        tbl[6]  = mk(1, 5'd8,  5'd7,  2'b01, 5'd3,  1, 1, 1, 0, 1, 2'd0, 2'd0, 0); // no-we, unused
        tbl[7]  = mk(1, 5'd3,  5'd3,  2'b11, 5'd4,  1, 0, 1, 0, 0, 2'd0, 2'd0, 1); // load-use
        tbl[8]  = mk(1, 5'd3,  5'd3,  2'b11, 5'd4,  1, 0, 1, 0, 1, 2'd2, 2'd2, 0); // after bubble
        tbl[9]  = mk(1, 5'd4,  5'd0,  2'b01, 5'd9,  1, 1, 1, 0, 1, 2'd1, 2'd0, 0); // lw x9
        tbl[10] = mk(1, 5'd9,  5'd4,  2'b11, 5'd10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1); // hold 1
        tbl[11] = mk(1, 5'd9,  5'd4,  2'b11, 5'd10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1); // hold 2
        tbl[12] = mk(1, 5'd9,  5'd4,  2'b11, 5'd10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1); // hold 3
        tbl[13] = mk(1, 5'd9,  5'd4,  2'b11, 5'd10, 1, 0, 1, 0, 0, 2'd0, 2'd0, 1); // advance stall
        tbl[14] = mk(1, 5'd9,  5'd4,  2'b11, 5'd10, 1, 0, 1, 0, 1, 2'd2, 2'd3, 0);
        tbl[15] = mk(1, 5'd10, 5'd0,  2'b01, 5'd11, 1, 1, 1, 0, 1, 2'd1, 2'd0, 0); // lw x11
        tbl[16] = mk(1, 5'd11, 5'd0,  2'b01, 5'd12, 1, 0, 1, 1, 1, 2'd1, 2'd0, 0); // flush
        tbl[17] = mk(1, 5'd11, 5'd12, 2'b11, 5'd13, 0, 0, 1, 0, 1, 2'd2, 2'd0, 0); // x12 squashed
        tbl[18] = mk(0, 5'd11, 5'd10, 2'b11, 5'd14, 1, 0, 1, 0, 1, 2'd0, 2'd0, 0); // id_valid=0

        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 1, 0);
        #12;
        check("reset_sel0",  int'(fwd_sel[1:0]), 0);
        check("reset_sel1",  int'(fwd_sel[3:2]), 0);
        check("reset_stall", int'(stall_id), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("reset_cnt", int'(stall_cnt), 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].rd,
                  tbl[i].we, tbl[i].ld, tbl[i].adv, tbl[i].fl);
            #1;
            check($sformatf("row%0d_stall", i), int'(stall_id), int'(tbl[i].est));
            if (tbl[i].chk_sel) begin
                check($sformatf("row%0d_sel0", i), int'(fwd_sel[1:0]), int'(tbl[i].e0));
                check($sformatf("row%0d_sel1", i), int'(fwd_sel[3:2]), int'(tbl[i].e1));
            end
            step();
        end

        // Async reset in the middle of a load-use stall.
        drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 1, 0);
        step();
        drive(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0, 1, 0);
        #1;
        check("pre_reset_stall", int'(stall_id), 1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_stall", int'(stall_id), 0);
        check("midreset_sel0",  int'(fwd_sel[1:0]), 0);
        check("midreset_sel1",  int'(fwd_sel[3:2]), 0);
        @(negedge clk);
        reset = 1'b1;

`ifdef HAZARD_STALL_CNT_EN
        check("cnt_after_reset", int'(stall_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 1, 0);
            step();
            drive(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0, 1, 0);
            step();
        end
        #1;
        check("cnt_five", int'(stall_cnt), 5);
`endif

        // Clean pipeline for the LOAD_LAT=2 sequence.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);

        drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 1, 0);
        step();
        drive(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0, 1, 0);
        #1;
        check("lat2_stall_a", int'(stall_id2), 1);
        check("lat1_stall_a", int'(stall_id), 1);
        step();
        #1;
        check("lat2_stall_b", int'(stall_id2), 1);
        check("lat1_stall_b", int'(stall_id), 0);
        check("lat1_sel0_b",  int'(fwd_sel[1:0]), 2);
        step();
        #1;
        check("lat2_stall_c", int'(stall_id2), 0);
        check("lat2_sel0_c",  int'(fwd_sel2[2:0]), 3);
        check("lat2_sel1_c",  int'(fwd_sel2[5:3]), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
